systolic_tile_sched: RTL and testbench
======================================

// Module: systolic_tile_sched
// PURPOSE
//  Sequences one matrix tile through the systolic-array datapath.
//  - Accepts DIM A-rows, then DIM B-columns, over a valid/ready load port; steers each into its preload FIFO with a one-hot write strobe.
//  - Broadcasts the FIFO shift enable for the full skewed compute window.
//  - Walks the DIM result rows out over a valid/ready read port, then pulses done.
//  - Sits between the host/MMIO front end and the preload-FIFO + PE array.
// PARAMETERS
//  DIM   8  array dimension: FIFOs per operand, rows per tile
//  CW    $clog2(3*DIM)  internal counter width (derived; do not override)
// PORTS
//  clk         in   1    clock, all state on posedge
//  rst         in   1    reset, synchronous, active-high
//  start       in   1    begin a tile; honoured in IDLE only
//  busy        out  1    1 in every state except IDLE
//  done        out  1    one-cycle pulse, tile complete
//  array_clr   out  1    one-cycle pulse clearing PE accumulators
//  ld_valid    in   1    load row present (row data routed outside this block)
//  ld_ready    out  1    load row accepted when ld_valid & ld_ready
//  fifo_wr_a   out  DIM  one-hot preload strobe, A FIFOs
//  fifo_wr_b   out  DIM  one-hot preload strobe, B FIFOs
//  fifo_en     out  1    shift enable, all preload FIFOs and PE array
//  res_valid   out  1    result row res_idx available
//  res_ready   in   1    consumer takes result row
//  res_idx     out  $clog2(DIM)  result row select
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; every output 0. rst overrides all other inputs.
//  States: IDLE -> LOAD -> COMPUTE -> READ -> DONE -> IDLE.
//  IDLE:
//   - start=1 -> LOAD next cycle.
//   - array_clr=1 during the first LOAD cycle only.
//   - ld_valid/res_ready ignored.
//  LOAD:
//   - ld_ready=1.
//   - Handshake = ld_valid & ld_ready.
//   - row_cnt 0..DIM-1 asserts fifo_wr_a[row_cnt]; DIM..2*DIM-1 asserts fifo_wr_b[row_cnt-DIM].
//   - Strobes are combinational, same cycle as the handshake; at most one bit set; 0 without a handshake.
//   - Handshake at row_cnt=2*DIM-1 -> COMPUTE, cyc_cnt=0.
//   - ld_valid gaps stall without penalty.
//  COMPUTE:
//   - fifo_en=1 every cycle; cyc_cnt++.
//   - cyc_cnt=3*DIM-3 -> READ. Exactly 3*DIM-2 enable cycles (22 for DIM=8): skew fill + DIM data + array drain.
//   - No input stalls COMPUTE.
//  READ:
//   - res_valid=1, res_idx=rd_cnt.
//   - res_ready=1 advances rd_cnt; res_ready=0 holds res_idx stable.
//   - Handshake at rd_cnt=DIM-1 -> DONE.
//  DONE: done=1 for one cycle, busy=1 -> IDLE.
//  start while busy (incl. DONE) is ignored, never queued.
//  start in same cycle as rst: reset wins, stays IDLE.
//  Counters wrap only via state exit; never past their terminal values.
//  ld_ready, fifo_en, res_valid decode from state (glitch-free w.r.t. inputs).
// CONFIGURATION
//  SCHED_ABORT_EN defined:
//   - Adds input port abort (1 bit).
//   - abort=1 forces ld_ready, fifo_wr_*, fifo_en, res_valid to 0 that same cycle; IDLE next cycle.
//   - No done pulse; counters cleared.
//   - rst has priority over abort; abort in IDLE is a no-op.
//  SCHED_ABORT_EN undefined: no abort port; a started tile always runs to DONE.
// TESTING (DIM=8)
//  1. rst 2 cycles, start, 16 back-to-back ld_valid, res_ready=1 ->
//     - array_clr one pulse; fifo_wr_a bits 0..7 then fifo_wr_b bits 0..7, one per cycle;
//     - fifo_en high 22 consecutive cycles; res_idx 0..7; done 1 cycle; busy falls.
//  2. ld_valid toggling 1,0,1,0 -> 16 strobes total, in order; no strobe on the idle cycles; COMPUTE starts after 16th handshake.
//  3. res_ready low 3 cycles at rd_cnt=4 -> res_idx holds 4, res_valid stays 1; done exactly 1 cycle after the rd_cnt=7 handshake.
//  4. start pulsed during COMPUTE and DONE -> no restart, no extra array_clr; next start in IDLE runs a normal tile.
//  5. rst asserted mid-COMPUTE (cyc_cnt=10) -> next cycle busy=0, fifo_en=0, all outputs 0; following tile timing identical to test 1.
//  6. SCHED_ABORT_EN: abort at row_cnt=5 in LOAD -> ld_ready=0 same cycle, IDLE next cycle, no done; rerun passes test 1.

Source files
------------

// File: rtl/systolic_tile_sched_if.sv
`default_nettype none
// =============================================================================
// Module   : systolic_tile_sched_if
// Purpose  : Handshake/control bundle between the tile scheduler and its users.
//            Macro SCHED_ABORT_EN adds the abort input.
// Revision : 1.0
// =============================================================================
interface systolic_tile_sched_if #(
  parameter int DIM = 8
);
  localparam int IW = $clog2(DIM);

  logic           start;
  logic           busy;
  logic           done;
  logic           array_clr;
  logic           ld_valid;
  logic           ld_ready;
  logic [DIM-1:0] fifo_wr_a;
  logic [DIM-1:0] fifo_wr_b;
  logic           fifo_en;
  logic           res_valid;
  logic           res_ready;
  logic [IW-1:0]  res_idx;
`ifdef SCHED_ABORT_EN
  logic           abort;

  modport master (
    output start, ld_valid, res_ready, abort,
    input  busy, done, array_clr, ld_ready, fifo_wr_a, fifo_wr_b,
    input  fifo_en, res_valid, res_idx
  );
  modport slave (
    input  start, ld_valid, res_ready, abort,
    output busy, done, array_clr, ld_ready, fifo_wr_a, fifo_wr_b,
    output fifo_en, res_valid, res_idx
  );
`else
  modport master (
    output start, ld_valid, res_ready,
    input  busy, done, array_clr, ld_ready, fifo_wr_a, fifo_wr_b,
    input  fifo_en, res_valid, res_idx
  );
  modport slave (
    input  start, ld_valid, res_ready,
    output busy, done, array_clr, ld_ready, fifo_wr_a, fifo_wr_b,
    output fifo_en, res_valid, res_idx
  );
`endif
endinterface
`default_nettype wire

// File: rtl/systolic_tile_sched.sv
`default_nettype none
// =============================================================================
// Module   : systolic_tile_sched
// Purpose  : Sequences one tile: load A/B rows, skewed compute, read results.
//            Macro SCHED_ABORT_EN adds an abort input that returns to IDLE.
// Revision : 1.0
// =============================================================================
module systolic_tile_sched #(
  parameter int DIM = 8,
  parameter int CW  = $clog2(3*DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_tile_sched_if.slave  bus
);
  localparam int IW = $clog2(DIM);

  localparam logic [CW-1:0] c_row_b    = CW'(DIM);
  localparam logic [CW-1:0] c_row_last = CW'(2*DIM-1);
  localparam logic [CW-1:0] c_cyc_last = CW'(3*DIM-3);
  localparam logic [IW-1:0] c_rd_last  = IW'(DIM-1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_READ    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_row_cnt, w_row_nxt;
  logic [CW-1:0] r_cyc_cnt, w_cyc_nxt;
  logic [IW-1:0] r_rd_cnt, w_rd_nxt;
  logic          r_clr;
  logic          w_abort;

`ifdef SCHED_ABORT_EN
  assign w_abort = bus.abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Registered so the clear lands exactly on the first LOAD cycle.
  assign bus.array_clr = r_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_row_cnt <= '0;
      r_cyc_cnt <= '0;
      r_rd_cnt  <= '0;
      r_clr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_nxt;
      r_cyc_cnt <= w_cyc_nxt;
      r_rd_cnt  <= w_rd_nxt;
      r_clr     <= (r_state == S_IDLE) && bus.start;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row_cnt;
    w_cyc_nxt     = r_cyc_cnt;
    w_rd_nxt      = r_rd_cnt;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.fifo_wr_a = '0;
    bus.fifo_wr_b = '0;
    bus.fifo_en   = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_idx   = r_rd_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          if (r_row_cnt < c_row_b) bus.fifo_wr_a = DIM'(1) << r_row_cnt;
          else                     bus.fifo_wr_b = DIM'(1) << (r_row_cnt - c_row_b);
          if (r_row_cnt == c_row_last) begin
            w_row_nxt   = '0;
            w_cyc_nxt   = '0;
            w_state_nxt = S_COMPUTE;
          end else begin
            w_row_nxt = r_row_cnt + CW'(1);
          end
        end
      end
      S_COMPUTE: begin
        bus.fifo_en = 1'b1;
        if (r_cyc_cnt == c_cyc_last) begin
          w_cyc_nxt   = '0;
          w_state_nxt = S_READ;
        end else begin
          w_cyc_nxt = r_cyc_cnt + CW'(1);
        end
      end
      S_READ: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          if (r_rd_cnt == c_rd_last) begin
            w_rd_nxt    = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_rd_nxt = r_rd_cnt + IW'(1);
          end
        end
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort gates the datapath controls in the same cycle it is seen.
    if (w_abort) begin
      bus.done      = 1'b0;
      bus.ld_ready  = 1'b0;
      bus.fifo_wr_a = '0;
      bus.fifo_wr_b = '0;
      bus.fifo_en   = 1'b0;
      bus.res_valid = 1'b0;
      w_row_nxt     = '0;
      w_cyc_nxt     = '0;
      w_rd_nxt      = '0;
      w_state_nxt   = S_IDLE;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_sched.sv
`default_nettype none
// =============================================================================
// Module   : tb_systolic_tile_sched
// Purpose  : Directed self-checking bench with strobe/result scoreboards.
// Revision : 1.0
// =============================================================================
module tb_systolic_tile_sched;
  localparam int DIM = 8;

  logic clk = 1'b0;
  logic rst;
  int   nerr = 0;
  int   nchk = 0;
  int   clr_cnt = 0;
  int   done_cnt = 0;
  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];

  systolic_tile_sched_if #(.DIM(DIM)) bus ();
  systolic_tile_sched #(.DIM(DIM)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.busy, bus.done, bus.array_clr, bus.ld_ready, bus.fifo_wr_a,
                bus.fifo_wr_b, bus.fifo_en, bus.res_valid, bus.res_idx});
  endfunction

  // Scoreboard side: strobes and result handshakes are popped as they appear.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (bus.array_clr) clr_cnt++;
      if (bus.done) done_cnt++;
      if ((bus.fifo_wr_a | bus.fifo_wr_b) != '0) begin
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", 32'({bus.fifo_wr_b, bus.fifo_wr_a}), 32'd0);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_strobe", 32'({bus.fifo_wr_b, bus.fifo_wr_a}), e);
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_rd_q.size() == 0) begin
          check("rd_unexpected", 32'(bus.res_valid & bus.res_ready), 32'd0);
        end else begin
          e = exp_rd_q.pop_front();
          check("rd_idx", 32'(bus.res_idx), e);
        end
      end
    end
  end

  task automatic run_tile(input bit gaps, input int stall_at, input bit start_cmp,
                          input bit start_done, input int rst_at);
    int k, g, r, stall, c0, d0;
    c0 = clr_cnt;
    d0 = done_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    nxt();
    bus.start = 1'b0;

    k = 0;
    g = 0;
    while (k < 2*DIM && g < 8*DIM) begin
      bus.ld_valid = gaps ? ~g[0] : 1'b1;
      if (bus.ld_valid) begin
        exp_wr_q.push_back(32'd1 << k);
        k++;
      end
      @(negedge clk);
      if (g == 0) check("array_clr_first", 32'(bus.array_clr), 32'd1);
      check("ld_ready", 32'(bus.ld_ready), 32'd1);
      nxt();
      g++;
    end
    bus.ld_valid = 1'b0;

    for (int i = 0; i < 3*DIM-2; i++) begin
      if (start_cmp && i == 5) bus.start = 1'b1;
      if (rst_at == i) rst = 1'b1;
      @(negedge clk);
      check("compute_outs", 32'({bus.ld_ready, bus.fifo_en, bus.res_valid}), 32'b010);
      nxt();
      bus.start = 1'b0;
      if (rst_at == i) begin
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", outs(), 32'd0);
        nxt();
        return;
      end
    end

    r = 0;
    g = 0;
    stall = 3;
    while (r < DIM && g < 4*DIM) begin
      bus.res_ready = !(r == stall_at && stall > 0);
      if (bus.res_ready) exp_rd_q.push_back(32'(r));
      @(negedge clk);
      check("read_valid", 32'({bus.fifo_en, bus.res_valid}), 32'b01);
      if (!bus.res_ready) begin
        check("read_hold", 32'(bus.res_idx), 32'(r));
        stall--;
      end else begin
        r++;
      end
      nxt();
      g++;
    end
    bus.res_ready = 1'b0;

    if (start_done) bus.start = 1'b1;
    @(negedge clk);
    check("done_state", 32'({bus.busy, bus.done}), 32'b11);
    nxt();
    bus.start = 1'b0;
    @(negedge clk);
    check("after_done", 32'({bus.busy, bus.done, bus.array_clr}), 32'd0);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("clr_pulses", 32'(clr_cnt - c0), 32'd1);
    check("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    nxt();
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.res_ready = 1'b0;
`ifdef SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif
    nxt();
    bus.start = 1'b1;
    nxt();
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    nxt();

    run_tile(1'b0, -1, 1'b0, 1'b0, -1);
    run_tile(1'b1, -1, 1'b0, 1'b0, -1);
    run_tile(1'b0,  4, 1'b0, 1'b0, -1);
    run_tile(1'b0, -1, 1'b1, 1'b1, -1);
    run_tile(1'b0, -1, 1'b0, 1'b0, -1);
    run_tile(1'b0, -1, 1'b0, 1'b0, 10);
    run_tile(1'b0, -1, 1'b0, 1'b0, -1);

`ifdef SCHED_ABORT_EN
    d0 = done_cnt;
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.ld_valid = 1'b1;
      exp_wr_q.push_back(32'd1 << k);
      nxt();
    end
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_gate", 32'({bus.ld_ready, bus.fifo_wr_a, bus.fifo_wr_b}), 32'd0);
    nxt();
    bus.abort = 1'b0;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'({bus.busy, bus.done, bus.ld_ready}), 32'd0);
    nxt();
    nxt();
    @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    nxt();
    run_tile(1'b0, -1, 1'b0, 1'b0, -1);
`else
    d0 = done_cnt;
    @(negedge clk);
    check("idle_no_done", 32'({bus.busy, bus.done}), 32'd0);
    check("done_total", 32'(d0), 32'd6);
    nxt();
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
